mgmt_sram_ctrl: RTL and testbench
=================================

# mgmt_sram_ctrl

Parametrised single-clock SRAM controller for the management SoC. It replaces the fixed 256-word DFFRAM hookup with a banked, byte-writable store of configurable depth. It arbitrates a single physical access per cycle between the CPU data port and a read-only housekeeping port, using CPU priority and a bounded-wait starvation guard. It sits between `mgmt_core` and the memory macros inside the core wrapper.

## Interface
Parameters:
- `BANKS`, 1: number of 256×32 banks; must be a power of two (1, 2, 4, 8).
- `ADDR_W`, 8+log2(BANKS): word address width; derived, not overridden.
- `MAX_WAIT`, 4: cycles a pending housekeeping read may be refused before it is forced through (1..15).

Ports:
- `core_clk` in 1: single clock; all logic rising-edge.
- `core_rst` in 1: reset, asynchronous and active-high.
- `core_en` in 1: CPU access request; hold until accepted.
- `core_we` in 4: byte write enables; 0 = read.
- `core_addr` in ADDR_W: CPU word address.
- `core_wdata` in 32: CPU write data.
- `core_stall` out 1: CPU request refused this cycle (combinational).
- `core_ack` out 1: one-cycle pulse, access completed.
- `core_rdata` out 32: read data, valid with `core_ack`.
- `ro_req` in 1: housekeeping read request; hold until `ro_valid`.
- `ro_addr` in ADDR_W: housekeeping word address.
- `ro_valid` out 1: one-cycle pulse, read data valid.
- `ro_data` out 32: housekeeping read data.
- `wait_cnt` out 4: current housekeeping wait count (debug).

## Operation
- Bank select = `addr[ADDR_W-1:8]`; word = `addr[7:0]`. Exactly one bank is accessed per cycle.
- Arbitration is evaluated in each cycle T:
  - FORCE = `ro_req && wait_cnt == MAX_WAIT`.
  - If FORCE: ro is granted and `core_stall` = `core_en`.
  - Else if `core_en`: core is granted, `core_stall` = 0.
  - Else if `ro_req`: ro is granted.
  - Else: idle.
- `wait_cnt` update:
  - Resets to 0 on any ro grant, and whenever `ro_req` is low.
  - Increments, saturating at MAX_WAIT, when `ro_req` is high and ro is not granted.
- Core write: bytes with `core_we[i]` set are updated at the edge ending T; other bytes are preserved; `core_ack` pulses at T+1 and `core_rdata` is don't-care.
- Core read: `core_rdata` = stored word at T+1 with `core_ack`.
- RO read: `ro_data` = stored word at T+1 with `ro_valid`. The requester must drop or change `ro_req` in the cycle of `ro_valid`. If `ro_req` is still high at T+1, it is treated as a new request.
- `ro_data` and `core_rdata` hold their last value when not valid.
- Writes and reads are never concurrent, so there is no read-during-write hazard. A read granted in the cycle after a write to the same address returns the new data.

## Timing
- Latency: one cycle from grant to `core_ack`/`ro_valid`.
- Throughput: one access per cycle total.
- Maximum core stall: 1 cycle per MAX_WAIT+1 cycles while ro is continuously requested.
- Maximum ro latency: MAX_WAIT+1 cycles from `ro_req` rise to `ro_valid`.
- Reset values: `core_ack`, `ro_valid`, `core_rdata`, `ro_data` and `wait_cnt` = 0. `core_stall` is 0 whenever reset is asserted.
- Reset asserted mid-access: pending `core_ack`/`ro_valid` are dropped (not issued after release). A write whose edge coincides with reset assertion is not guaranteed. Memory contents are not reset (X in simulation).
- First grant is possible in the first cycle after `core_rst` deasserts.

## Configuration
- `MGMT_SRAM_PARITY_EN` defined:
  - One even-parity bit is stored per byte, written with each enabled byte.
  - Every read (core or ro) is checked at T+1.
  - A mismatch sets sticky output `parity_err` (1 bit, reset 0). It is cleared only by `core_rst` or by input `parity_clr` (1 bit; when sampled high, the clear overrides a simultaneous set).
  - Ports `parity_err`/`parity_clr` exist only with this macro.
- Undefined: no parity storage, no extra ports, no check logic.

## Test plan
- Write `core_we`=4'hF, addr 0x005, data 0xDEADBEEF; then read addr 0x005 → `core_ack` at T+1, `core_rdata`=0xDEADBEEF.
- Write `core_we`=4'b0010 data 0x0000AA00 to the word holding 0x11223344 → read returns 0x1122AA44.
- BANKS=4: write distinct values to 0x0FF and 0x3FF → each reads back independently, with no aliasing.
- `core_en` held high every cycle, `ro_req` high, MAX_WAIT=4 → `wait_cnt` 0,1,2,3,4; `core_stall`=1 in the cycle `wait_cnt`=4; `ro_valid` one cycle later with correct data; `wait_cnt` returns to 0.
- `ro_req` alone, idle core → `ro_valid` at T+1 and `wait_cnt` stays 0. Assert `core_rst` in the grant cycle → no `ro_valid`, and all outputs are 0.
- With `MGMT_SRAM_PARITY_EN`: force one stored data bit flip via hierarchical deposit, then read → `parity_err`=1 and remains 1; pulse `parity_clr` → `parity_err`=0.

Source files
------------

// File: rtl/mgmt_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mgmt_sram_ctrl
// Purpose  : Banked byte-writable SRAM controller arbitrating a CPU port and a
//            read-only housekeeping port; optional per-byte parity via the
//            MGMT_SRAM_PARITY_EN macro.
// Revision : 1.0
// ============================================================================
module mgmt_sram_ctrl #(
    parameter int BANKS    = 1,
    parameter int ADDR_W   = 8 + $clog2(BANKS),
    parameter int MAX_WAIT = 4
) (
    input  logic              core_clk,
    input  logic              core_rst,
    input  logic              core_en,
    input  logic [3:0]        core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_wdata,
    output logic              core_stall,
    output logic              core_ack,
    output logic [31:0]       core_rdata,
    input  logic              ro_req,
    input  logic [ADDR_W-1:0] ro_addr,
    output logic              ro_valid,
    output logic [31:0]       ro_data,
`ifdef MGMT_SRAM_PARITY_EN
    output logic              parity_err,
    input  logic              parity_clr,
`endif
    output logic [3:0]        wait_cnt
);

    localparam int BSEL_W = (BANKS > 1) ? $clog2(BANKS) : 1;

    logic              force_ro;
    logic              ro_grant;
    logic              core_grant;
    logic              wr_en;
    logic              core_rd_en;
    logic [ADDR_W-1:0] acc_addr;
    logic [7:0]        word_sel;
    logic [BSEL_W-1:0] bank_sel;
    logic [31:0]       bank_rd [BANKS];
    logic [31:0]       rd_word;

    // Housekeeping is forced through once it has been refused MAX_WAIT times.
    assign force_ro   = ro_req && (wait_cnt == 4'(MAX_WAIT));
    assign ro_grant   = force_ro || (!core_en && ro_req);
    assign core_grant = core_en && !force_ro;
    assign core_stall = core_en && force_ro && !core_rst;
    assign wr_en      = core_grant && (core_we != 4'b0000);
    assign core_rd_en = core_grant && (core_we == 4'b0000);

    assign acc_addr = ro_grant ? ro_addr : core_addr;
    assign word_sel = acc_addr[7:0];

    generate
        if (BANKS > 1) begin : g_multi_bank
            assign bank_sel = acc_addr[ADDR_W-1:8];
        end else begin : g_single_bank
            assign bank_sel = '0;
        end
    endgenerate

`ifdef MGMT_SRAM_PARITY_EN
    logic [3:0] bank_par [BANKS];
    logic [3:0] rd_par;
    logic       par_bad;
`endif

    generate
        for (genvar b = 0; b < BANKS; b++) begin : g_bank
            logic [31:0] mem [256];
`ifdef MGMT_SRAM_PARITY_EN
            logic [3:0]  par [256];
`endif
            always_ff @(posedge core_clk) begin
                if (wr_en && (bank_sel == BSEL_W'(b))) begin
                    for (int i = 0; i < 4; i++) begin
                        if (core_we[i]) begin
                            mem[word_sel][8*i +: 8] <= core_wdata[8*i +: 8];
`ifdef MGMT_SRAM_PARITY_EN
                            par[word_sel][i]        <= ^core_wdata[8*i +: 8];
`endif
                        end
                    end
                end
            end
            assign bank_rd[b] = mem[word_sel];
`ifdef MGMT_SRAM_PARITY_EN
            assign bank_par[b] = par[word_sel];
`endif
        end
    endgenerate

    assign rd_word = bank_rd[bank_sel];

`ifdef MGMT_SRAM_PARITY_EN
    // Evaluated with the read so the sticky flag lands alongside the data.
    assign rd_par  = bank_par[bank_sel];
    assign par_bad = (ro_grant || core_rd_en) &&
                     ({^rd_word[31:24], ^rd_word[23:16], ^rd_word[15:8], ^rd_word[7:0]} != rd_par);

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            parity_err <= 1'b0;
        end else if (parity_clr) begin
            parity_err <= 1'b0;
        end else if (par_bad) begin
            parity_err <= 1'b1;
        end
    end
`endif

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            core_ack   <= 1'b0;
            core_rdata <= 32'h0;
            ro_valid   <= 1'b0;
            ro_data    <= 32'h0;
            wait_cnt   <= 4'h0;
        end else begin
            core_ack <= core_grant;
            ro_valid <= ro_grant;
            if (core_rd_en) begin
                core_rdata <= rd_word;
            end
            if (ro_grant) begin
                ro_data <= rd_word;
            end
            if (!ro_req || ro_grant) begin
                wait_cnt <= 4'h0;
            end else if (wait_cnt != 4'(MAX_WAIT)) begin
                wait_cnt <= wait_cnt + 4'h1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mgmt_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mgmt_sram_ctrl
// Purpose  : Directed self-checking bench for mgmt_sram_ctrl (BANKS=4).
// Revision : 1.0
// ============================================================================
module tb_mgmt_sram_ctrl;

    localparam int BANKS    = 4;
    localparam int ADDR_W   = 10;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              core_en;
    logic [3:0]        core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [31:0]       core_wdata;
    logic              core_stall;
    logic              core_ack;
    logic [31:0]       core_rdata;
    logic              ro_req;
    logic [ADDR_W-1:0] ro_addr;
    logic              ro_valid;
    logic [31:0]       ro_data;
    logic [3:0]        wait_cnt;
`ifdef MGMT_SRAM_PARITY_EN
    logic              parity_err;
    logic              parity_clr;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mgmt_sram_ctrl #(
        .BANKS    (BANKS),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .core_clk   (clk),
        .core_rst   (rst),
        .core_en    (core_en),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_stall (core_stall),
        .core_ack   (core_ack),
        .core_rdata (core_rdata),
        .ro_req     (ro_req),
        .ro_addr    (ro_addr),
        .ro_valid   (ro_valid),
        .ro_data    (ro_data),
`ifdef MGMT_SRAM_PARITY_EN
        .parity_err (parity_err),
        .parity_clr (parity_clr),
`endif
        .wait_cnt   (wait_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core_op(input logic [3:0] we, input logic [ADDR_W-1:0] a, input logic [31:0] d);
        core_en    = 1'b1;
        core_we    = we;
        core_addr  = a;
        core_wdata = d;
        tick();
        core_en    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; core_en = 1'b0; core_we = 4'h0; core_addr = '0; core_wdata = 32'h0;
        ro_req = 1'b0; ro_addr = '0;
`ifdef MGMT_SRAM_PARITY_EN
        parity_clr = 1'b0;
`endif
        tick(); tick();
        chk("rst_ack", 32'(core_ack), 32'h0);
        chk("rst_valid", 32'(ro_valid), 32'h0);
        chk("rst_rdata", core_rdata, 32'h0);
        chk("rst_ro_data", ro_data, 32'h0);
        chk("rst_wait", 32'(wait_cnt), 32'h0);
        core_en = 1'b1;
        #1;
        chk("rst_stall", 32'(core_stall), 32'h0);
        core_en = 1'b0;
        rst = 1'b0;

        // Full write then read of the same word on the next cycle.
        core_en = 1'b1; core_we = 4'hF; core_addr = 10'h005; core_wdata = 32'hDEADBEEF;
        #1;
        chk("wr_stall", 32'(core_stall), 32'h0);
        tick();
        chk("wr_ack", 32'(core_ack), 32'h1);
        core_op(4'h0, 10'h005, 32'h0);
        chk("rd_ack", 32'(core_ack), 32'h1);
        chk("rd_data", core_rdata, 32'hDEADBEEF);
        tick();
        chk("ack_pulse", 32'(core_ack), 32'h0);
        chk("rdata_hold", core_rdata, 32'hDEADBEEF);

        // Byte-lane write.
        core_op(4'hF, 10'h010, 32'h11223344);
        core_op(4'b0010, 10'h010, 32'h0000AA00);
        core_op(4'h0, 10'h010, 32'h0);
        chk("byte_wr", core_rdata, 32'h1122AA44);

        // Same word offset in different banks must not alias.
        core_op(4'hF, 10'h0FF, 32'hA5A50001);
        core_op(4'hF, 10'h3FF, 32'h5A5A0002);
        core_op(4'h0, 10'h0FF, 32'h0);
        chk("bank0_ff", core_rdata, 32'hA5A50001);
        core_op(4'h0, 10'h3FF, 32'h0);
        chk("bank3_ff", core_rdata, 32'h5A5A0002);

        // Continuous core reads starve ro until the wait guard forces it.
        core_en = 1'b1; core_we = 4'h0; core_addr = 10'h0FF;
        ro_req = 1'b1; ro_addr = 10'h005;
        for (int k = 0; k < MAX_WAIT; k++) begin
            #1;
            chk($sformatf("starve_wait%0d", k), 32'(wait_cnt), 32'(k));
            chk($sformatf("starve_stall%0d", k), 32'(core_stall), 32'h0);
            tick();
            chk($sformatf("starve_ack%0d", k), 32'(core_ack), 32'h1);
            chk($sformatf("starve_rvalid%0d", k), 32'(ro_valid), 32'h0);
        end
        #1;
        chk("force_wait", 32'(wait_cnt), 32'(MAX_WAIT));
        chk("force_stall", 32'(core_stall), 32'h1);
        tick();
        ro_req = 1'b0;
        chk("force_valid", 32'(ro_valid), 32'h1);
        chk("force_data", ro_data, 32'hDEADBEEF);
        chk("force_no_ack", 32'(core_ack), 32'h0);
        chk("force_wait0", 32'(wait_cnt), 32'h0);
        tick();
        chk("post_force_ack", 32'(core_ack), 32'h1);
        chk("post_force_rdata", core_rdata, 32'hA5A50001);
        core_en = 1'b0;

        // Lone ro request is granted immediately.
        ro_req = 1'b1; ro_addr = 10'h3FF;
        #1;
        chk("ro_wait0", 32'(wait_cnt), 32'h0);
        tick();
        ro_req = 1'b0;
        chk("ro_valid", 32'(ro_valid), 32'h1);
        chk("ro_data", ro_data, 32'h5A5A0002);
        chk("ro_wait_still0", 32'(wait_cnt), 32'h0);
        tick();
        chk("ro_valid_pulse", 32'(ro_valid), 32'h0);
        chk("ro_data_hold", ro_data, 32'h5A5A0002);

        // Reset asserted during the ro grant cycle drops the pending response.
        ro_req = 1'b1; ro_addr = 10'h0FF;
        #2;
        rst = 1'b1;
        tick();
        chk("rstmid_valid", 32'(ro_valid), 32'h0);
        chk("rstmid_ack", 32'(core_ack), 32'h0);
        chk("rstmid_rdata", core_rdata, 32'h0);
        chk("rstmid_ro_data", ro_data, 32'h0);
        chk("rstmid_wait", 32'(wait_cnt), 32'h0);
        chk("rstmid_stall", 32'(core_stall), 32'h0);
        ro_req = 1'b0;
        rst = 1'b0;
        tick();
        chk("rstmid_valid_after", 32'(ro_valid), 32'h0);

        // First grant after reset release; memory contents survive reset.
        core_op(4'h0, 10'h005, 32'h0);
        chk("post_rst_ack", 32'(core_ack), 32'h1);
        chk("post_rst_data", core_rdata, 32'hDEADBEEF);

`ifdef MGMT_SRAM_PARITY_EN
        core_op(4'hF, 10'h020, 32'h0F0F0F0F);
        core_op(4'h0, 10'h020, 32'h0);
        chk("par_clean", 32'(parity_err), 32'h0);
        dut.g_bank[0].mem[8'h20][3] = ~dut.g_bank[0].mem[8'h20][3];
        core_op(4'h0, 10'h020, 32'h0);
        chk("par_set", 32'(parity_err), 32'h1);
        tick();
        chk("par_sticky", 32'(parity_err), 32'h1);
        parity_clr = 1'b1;
        tick();
        parity_clr = 1'b0;
        chk("par_clr", 32'(parity_err), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
